td4_core_p: RTL and testbench
=============================

TD4_CORE_P -- requirements
Module: td4_core_p

Interface
REQ-001 Parameter DW, default 4, sets the width of the data path, the A/B registers, the output port, the input port and the immediate field.
REQ-002 Parameter AW, default 4, sets the width of the program counter and the program address; legal only with AW >= DW.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces every register to its reset value immediately.
REQ-005 imem_addr  output  AW  program memory address; equals pc.
REQ-006 imem_data  input  4+DW  instruction from synchronous ROM, valid one clk after imem_addr; [DW+3:DW]=op, [DW-1:0]=im.
REQ-007 inp  input  DW  input port data.
REQ-008 in_valid  input  1  inp holds valid data this cycle.
REQ-009 in_ready  output  1  core consumes inp this cycle; high only in EXEC with op IN A or IN B.
REQ-010 outp  output  DW  registered output port (C register).
REQ-011 out_valid  output  1  one-cycle pulse, registered, high the cycle after outp is loaded.
REQ-012 halted  output  1  high while the core is in HALT.

Function
REQ-013 The core SHALL use a three-state FSM: FETCH, EXEC, HALT; after reset it is in FETCH.
REQ-014 FETCH: one cycle, ROM presents imem_data for pc; next state EXEC.
REQ-015 EXEC: decode imem_data, update registers, pc and carry at the end of the cycle, next state FETCH (or HALT); nominal cost 2 clk per instruction.
REQ-016 Opcode map: 0000 ADD A,im; 0101 ADD B,im; 0011 MOV A,im; 0111 MOV B,im; 0001 MOV A,B; 0100 MOV B,A; 0010 IN A; 0110 IN B; 1001 OUT B; 1011 OUT im; 1111 JMP im; 1110 JNC im; 1100 HALT; all others NOP.
REQ-017 ADD: DW+1-bit sum of register and im; low DW bits to the register, bit DW to carry; wrap-around modulo 2^DW.
REQ-018 Every executed instruction other than ADD SHALL clear carry; HALT also clears it.
REQ-019 JMP loads pc with im zero-extended to AW; JNC does so only if carry=0 as it stood before this instruction, otherwise pc+1.
REQ-020 All other instructions: pc <= pc+1 modulo 2^AW (2^AW-1 wraps to 0).
REQ-021 IN A/IN B: while in_valid=0 the core stays in EXEC with pc, registers and carry held, in_ready=1; the cycle in_valid=1 the register loads inp, then normal completion.
REQ-022 OUT B/OUT im load outp with B/im; out_valid=1 for exactly the following cycle; back-to-back OUTs give separate pulses 2 clk apart.
REQ-023 HALT: pc not incremented; state HALT is sticky, halted=1, no further imem use; only reset leaves it.
REQ-024 Register-to-register moves use pre-edge values (MOV A,B reads old B).

Reset
REQ-025 While reset=0: state=FETCH, pc=0, A=0, B=0, outp=0, carry=0, out_valid=0, halted=0, in_ready=0.
REQ-026 Reset asserted mid-instruction (including during an IN stall or HALT) SHALL abort it with no partial register update; first fetch after release is address 0.
REQ-027 Reset release is sampled by the next rising clk; imem_addr=0 during the first FETCH.

Verification
REQ-028 DW=4, ROM {0: MOV A,7; 1: ADD A,9; 2: JNC 0; 3: HALT} -> A=0 with carry=1 after cycle 4, JNC falls through, pc stops at 3, halted=1 at cycle 8.
REQ-029 ROM {0: OUT 5; 1: OUT B; 2: HALT} -> outp=5 and out_valid pulse, then outp=0 and second pulse 2 clk later, exactly two pulses total.
REQ-030 ROM {0: IN A; 1: OUT ...} with in_valid low 5 cycles then inp=0xA -> in_ready high 6 cycles, pc held at 0, A=0xA after accept.
REQ-031 AW=4: ROM all NOP -> pc counts 0..15 then 0, one increment per 2 clk.
REQ-032 DW=8, AW=8: ADD A,0xFF with A=0x01 -> A=0x00, carry=1; JMP 0xC8 -> pc=0xC8.
REQ-033 Reset pulsed during IN stall with A=3 -> A=0, pc=0, in_ready=0 immediately, fetch restarts at 0.

Source files
------------

// File: rtl/td4_core_p.sv
// TD4-style 4-op-class microcore: two-phase fetch/execute sequencer with A/B
// registers, carry flag, handshaked input port and registered output port.
//
// state   | meaning
// FETCH   | pc on imem_addr, ROM output settles for next cycle
// EXEC    | decode imem_data, update regs/pc/carry (IN may stall here)
// HALT    | terminal state, only reset leaves it
module td4_core_p #(
   parameter int DW = 4,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   output logic [AW-1:0] imem_addr,
   input  logic [DW+3:0] imem_data,
   input  logic [DW-1:0] inp,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] outp,
   output logic          out_valid,
   output logic          halted
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   localparam logic [3:0] OP_ADD_A  = 4'b0000;
   localparam logic [3:0] OP_ADD_B  = 4'b0101;
   localparam logic [3:0] OP_MOV_AI = 4'b0011;
   localparam logic [3:0] OP_MOV_BI = 4'b0111;
   localparam logic [3:0] OP_MOV_AB = 4'b0001;
   localparam logic [3:0] OP_MOV_BA = 4'b0100;
   localparam logic [3:0] OP_IN_A   = 4'b0010;
   localparam logic [3:0] OP_IN_B   = 4'b0110;
   localparam logic [3:0] OP_OUT_B  = 4'b1001;
   localparam logic [3:0] OP_OUT_I  = 4'b1011;
   localparam logic [3:0] OP_JMP    = 4'b1111;
   localparam logic [3:0] OP_JNC    = 4'b1110;
   localparam logic [3:0] OP_HALT   = 4'b1100;

   state_t        r_state;
   logic [AW-1:0] r_pc;
   logic [DW-1:0] r_a;
   logic [DW-1:0] r_b;
   logic [DW-1:0] r_outp;
   logic          r_carry;
   logic          r_out_valid;
   logic          r_halted;

   logic [3:0]    w_op;
   logic [DW-1:0] w_im;
   logic [AW-1:0] w_pc_inc;
   logic [DW:0]   w_sum_a;
   logic [DW:0]   w_sum_b;
   logic          w_is_in;

   assign w_op     = imem_data[DW+3:DW];
   assign w_im     = imem_data[DW-1:0];
   assign w_pc_inc = r_pc + AW'(1);
   assign w_sum_a  = {1'b0, r_a} + {1'b0, w_im};
   assign w_sum_b  = {1'b0, r_b} + {1'b0, w_im};
   assign w_is_in  = (r_state == S_EXEC) && ((w_op == OP_IN_A) || (w_op == OP_IN_B));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_FETCH;
         r_pc        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_outp      <= '0;
         r_carry     <= 1'b0;
         r_out_valid <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            S_FETCH: r_state <= S_EXEC;
            S_EXEC: begin
               // Defaults describe a normal non-ADD completion; opcodes override.
               r_state <= S_FETCH;
               r_pc    <= w_pc_inc;
               r_carry <= 1'b0;
               case (w_op)
                  OP_ADD_A: begin
                     r_a     <= w_sum_a[DW-1:0];
                     r_carry <= w_sum_a[DW];
                  end
                  OP_ADD_B: begin
                     r_b     <= w_sum_b[DW-1:0];
                     r_carry <= w_sum_b[DW];
                  end
                  OP_MOV_AI: r_a <= w_im;
                  OP_MOV_BI: r_b <= w_im;
                  OP_MOV_AB: r_a <= r_b;
                  OP_MOV_BA: r_b <= r_a;
                  OP_IN_A, OP_IN_B: begin
                     if (in_valid) begin
                        if (w_op == OP_IN_A) r_a <= inp;
                        else                 r_b <= inp;
                     end else begin
                        r_state <= S_EXEC;
                        r_pc    <= r_pc;
                        r_carry <= r_carry;
                     end
                  end
                  OP_OUT_B: begin
                     r_outp      <= r_b;
                     r_out_valid <= 1'b1;
                  end
                  OP_OUT_I: begin
                     r_outp      <= w_im;
                     r_out_valid <= 1'b1;
                  end
                  OP_JMP: r_pc <= AW'(w_im);
                  OP_JNC: begin
                     if (!r_carry) r_pc <= AW'(w_im);
                  end
                  OP_HALT: begin
                     r_state  <= S_HALT;
                     r_pc     <= r_pc;
                     r_halted <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign imem_addr = r_pc;
   assign in_ready  = w_is_in;
   assign outp      = r_outp;
   assign out_valid = r_out_valid;
   assign halted    = r_halted;

endmodule

// File: tb/tb_td4_core_p.sv
// Directed bench for td4_core_p: a 4-bit instance driven by an instruction
// table plus hand sequences, and an 8-bit instance for wide add/jump.
module tb_td4_core_p;

   logic clk;
   logic reset;

   logic [3:0]  addr4;
   logic [7:0]  rom4_q;
   logic [3:0]  inp4;
   logic        in_valid4;
   logic        in_ready4;
   logic [3:0]  outp4;
   logic        out_valid4;
   logic        halted4;

   logic [7:0]  addr8;
   logic [11:0] rom8_q;
   logic [7:0]  inp8;
   logic        in_valid8;
   logic        in_ready8;
   logic [7:0]  outp8;
   logic        out_valid8;
   logic        halted8;

   logic [7:0]  rom4 [16];
   logic [11:0] rom8 [256];

   int n_checks;
   int n_fail;

   td4_core_p #(.DW(4), .AW(4)) dut4 (
      .clk(clk), .reset(reset), .imem_addr(addr4), .imem_data(rom4_q),
      .inp(inp4), .in_valid(in_valid4), .in_ready(in_ready4),
      .outp(outp4), .out_valid(out_valid4), .halted(halted4)
   );

   td4_core_p #(.DW(8), .AW(8)) dut8 (
      .clk(clk), .reset(reset), .imem_addr(addr8), .imem_data(rom8_q),
      .inp(inp8), .in_valid(in_valid8), .in_ready(in_ready8),
      .outp(outp8), .out_valid(out_valid8), .halted(halted8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROMs: data for an address appears one clock later.
   always @(posedge clk) begin
      rom4_q <= rom4[addr4];
      rom8_q <= rom8[addr8];
   end

   typedef struct {
      logic [7:0] instr;
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      logic [3:0] pc;
      logic [3:0] outp;
      logic       ov;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic fill_rom4(input logic [7:0] v);
      for (int i = 0; i < 16; i++) rom4[i] = v;
   endtask

   initial begin
      int addr;
      int pulses;
      int p_cyc [4];
      logic [3:0] p_out [4];
      int ready_cnt;
      int waited;

      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b0;
      inp4      = '0;
      in_valid4 = 1'b0;
      inp8      = '0;
      in_valid8 = 1'b0;
      fill_rom4(8'hC0);
      for (int i = 0; i < 256; i++) rom8[i] = 12'hC00;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", addr4, 0);
      chk("rst_outp", outp4, 0);
      chk("rst_ov", out_valid4, 0);
      chk("rst_halted", halted4, 0);
      chk("rst_in_ready", in_ready4, 0);
      chk("rst_a", dut4.r_a, 0);

      // Instruction table: {instr, A, B, carry, pc, outp, out_valid} after each
      vecs[0]  = '{8'h37, 4'h7, 4'h0, 1'b0, 4'd1,  4'h0, 1'b0};
      vecs[1]  = '{8'h09, 4'h0, 4'h0, 1'b1, 4'd2,  4'h0, 1'b0};
      vecs[2]  = '{8'hE0, 4'h0, 4'h0, 1'b0, 4'd3,  4'h0, 1'b0};
      vecs[3]  = '{8'h05, 4'h5, 4'h0, 1'b0, 4'd4,  4'h0, 1'b0};
      vecs[4]  = '{8'h40, 4'h5, 4'h5, 1'b0, 4'd5,  4'h0, 1'b0};
      vecs[5]  = '{8'h5C, 4'h5, 4'h1, 1'b1, 4'd6,  4'h0, 1'b0};
      vecs[6]  = '{8'h10, 4'h1, 4'h1, 1'b0, 4'd7,  4'h0, 1'b0};
      vecs[7]  = '{8'h0F, 4'h0, 4'h1, 1'b1, 4'd8,  4'h0, 1'b0};
      vecs[8]  = '{8'h80, 4'h0, 4'h1, 1'b0, 4'd9,  4'h0, 1'b0};
      vecs[9]  = '{8'h90, 4'h0, 4'h1, 1'b0, 4'd10, 4'h1, 1'b1};
      vecs[10] = '{8'hBA, 4'h0, 4'h1, 1'b0, 4'd11, 4'hA, 1'b1};
      vecs[11] = '{8'h73, 4'h0, 4'h3, 1'b0, 4'd12, 4'hA, 1'b0};
      vecs[12] = '{8'h01, 4'h1, 4'h3, 1'b0, 4'd13, 4'hA, 1'b0};
      vecs[13] = '{8'hEF, 4'h1, 4'h3, 1'b0, 4'd15, 4'hA, 1'b0};
      vecs[14] = '{8'h0F, 4'h0, 4'h3, 1'b1, 4'd0,  4'hA, 1'b0};

      fill_rom4(8'hC0);
      addr = 0;
      for (int i = 0; i < 15; i++) begin
         rom4[addr] = vecs[i].instr;
         addr = int'(vecs[i].pc);
      end
      do_reset();
      for (int i = 0; i < 15; i++) begin
         step(1);
         chk($sformatf("v%0d_ov_fetch", i), out_valid4, 0);
         step(1);
         chk($sformatf("v%0d_a", i), dut4.r_a, vecs[i].a);
         chk($sformatf("v%0d_b", i), dut4.r_b, vecs[i].b);
         chk($sformatf("v%0d_c", i), dut4.r_carry, vecs[i].c);
         chk($sformatf("v%0d_pc", i), addr4, vecs[i].pc);
         chk($sformatf("v%0d_outp", i), outp4, vecs[i].outp);
         chk($sformatf("v%0d_ov", i), out_valid4, vecs[i].ov);
      end

      // MOV A,7; ADD A,9; JNC 0; HALT
      fill_rom4(8'hC0);
      rom4[0] = 8'h37; rom4[1] = 8'h09; rom4[2] = 8'hE0; rom4[3] = 8'hC0;
      do_reset();
      step(4);
      chk("p1_a", dut4.r_a, 0);
      chk("p1_carry", dut4.r_carry, 1);
      step(3);
      chk("p1_halted_c7", halted4, 0);
      step(1);
      chk("p1_halted_c8", halted4, 1);
      chk("p1_pc", addr4, 3);
      chk("p1_carry_clr", dut4.r_carry, 0);
      step(5);
      chk("p1_pc_sticky", addr4, 3);
      chk("p1_halt_sticky", halted4, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("halt_rst_halted", halted4, 0);
      chk("halt_rst_pc", addr4, 0);

      // OUT 5; OUT B; HALT
      fill_rom4(8'hC0);
      rom4[0] = 8'hB5; rom4[1] = 8'h90;
      do_reset();
      pulses = 0;
      for (int c = 1; c <= 20; c++) begin
         step(1);
         if (out_valid4) begin
            if (pulses < 4) begin
               p_cyc[pulses] = c;
               p_out[pulses] = outp4;
            end
            pulses++;
         end
      end
      chk("out_pulses", pulses, 2);
      if (pulses >= 2) begin
         chk("out_first_cyc", p_cyc[0], 2);
         chk("out_first_val", p_out[0], 5);
         chk("out_gap", p_cyc[1] - p_cyc[0], 2);
         chk("out_second_val", p_out[1], 0);
      end

      // IN A stall then accept; MOV B,A; OUT B
      fill_rom4(8'hC0);
      rom4[0] = 8'h20; rom4[1] = 8'h40; rom4[2] = 8'h90;
      in_valid4 = 1'b0;
      inp4 = 4'h0;
      do_reset();
      step(1);
      ready_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (in_ready4) ready_cnt++;
         chk($sformatf("in_stall_pc%0d", i), addr4, 0);
         step(1);
      end
      chk("in_stall_a", dut4.r_a, 0);
      in_valid4 = 1'b1;
      inp4 = 4'hA;
      #1;
      if (in_ready4) ready_cnt++;
      step(1);
      in_valid4 = 1'b0;
      inp4 = 4'h0;
      chk("in_ready_cycles", ready_cnt, 6);
      chk("in_accept_a", dut4.r_a, 4'hA);
      chk("in_accept_pc", addr4, 1);
      chk("in_ready_drop", in_ready4, 0);
      waited = 0;
      while (!out_valid4 && waited < 20) begin
         step(1);
         waited++;
      end
      chk("in_out_seen", out_valid4, 1);
      chk("in_out_val", outp4, 4'hA);

      // All NOP: pc walks 0..15 and wraps, one step per two clocks
      fill_rom4(8'h80);
      do_reset();
      for (int k = 0; k < 17; k++) begin
         step(1);
         chk($sformatf("nop_mid%0d", k), addr4, k % 16);
         step(1);
         chk($sformatf("nop_pc%0d", k), addr4, (k + 1) % 16);
      end

      // 8-bit: MOV A,1; ADD A,FF; JMP C8; HALT at C8
      rom8[0] = 12'h301; rom8[1] = 12'h0FF; rom8[2] = 12'hFC8;
      do_reset();
      step(2);
      chk("w8_mov", dut8.r_a, 8'h01);
      step(2);
      chk("w8_add_a", dut8.r_a, 8'h00);
      chk("w8_add_c", dut8.r_carry, 1);
      step(2);
      chk("w8_jmp_pc", addr8, 8'hC8);
      chk("w8_jmp_c", dut8.r_carry, 0);
      waited = 0;
      while (!halted8 && waited < 10) begin
         step(1);
         waited++;
      end
      chk("w8_halted", halted8, 1);
      chk("w8_halt_pc", addr8, 8'hC8);

      // Reset during IN stall
      fill_rom4(8'hC0);
      rom4[0] = 8'h33; rom4[1] = 8'h20;
      in_valid4 = 1'b0;
      do_reset();
      step(3);
      chk("rs_a_before", dut4.r_a, 3);
      chk("rs_ready_before", in_ready4, 1);
      step(2);
      chk("rs_pc_stall", addr4, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("rs_a", dut4.r_a, 0);
      chk("rs_pc", addr4, 0);
      chk("rs_ready", in_ready4, 0);
      @(negedge clk);
      reset = 1'b1;
      step(1);
      chk("rs_fetch_addr", addr4, 0);
      chk("rs_fetch_ready", in_ready4, 0);
      step(1);
      chk("rs_refetch_a", dut4.r_a, 3);
      chk("rs_refetch_pc", addr4, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
